// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: raster-scan 3x3 window generator and write-back sequencer for the Sobel datapath.
// Optional SOBEL_FRAME_STATS_EN adds edge_cnt_o (writes of 255 in the current frame).
`timescale 1ns/1ps
`default_nettype none

module sobel_window_ctrl #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              pix_valid_i,
  input  logic [7:0]        pix_i,
  output logic              pix_ready_o,
  output logic [71:0]       win_o,
  output logic              win_done_o,
  input  logic [7:0]        res_i,
  input  logic              res_done_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              busy_o,
  output logic              frame_done_o
`ifdef SOBEL_FRAME_STATS_EN
  ,
  output logic [ADDR_W-1:0] edge_cnt_o
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam logic [CW-1:0]     c_COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     c_ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0]     c_COL_ONE  = CW'(1);
  localparam logic [CW-1:0]     c_COL_TWO  = CW'(2);
  localparam logic [RW-1:0]     c_ROW_TWO  = RW'(2);
  localparam logic [ADDR_W-1:0] c_WR_TOTAL = ADDR_W'((IMG_W - 2) * (IMG_H - 2));
  localparam logic [ADDR_W-1:0] c_CTR_OFS  = ADDR_W'(IMG_W + 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [ADDR_W-1:0] r_pidx;
  logic [ADDR_W-1:0] r_wcnt;
  logic [7:0]        r_lb0 [IMG_W];
  logic [7:0]        r_lb1 [IMG_W];
  logic [7:0]        r_t1, r_t2, r_m1, r_m2, r_b1, r_b2;
  logic [71:0]       r_s1_win;
  logic              r_s1_done;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [71:0]       r_win;
  logic              r_win_done;
  logic [ADDR_W-1:0] r_win_addr;
  logic [ADDR_W-1:0] r_dly_addr [4];
  logic [3:0]        r_dly_vld;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_busy;
  logic              r_frame_done;

  logic              w_ready;
  logic              w_accept;
  logic              w_start;
  logic              w_last_pix;
  logic              w_win_issue;
  logic [7:0]        w_top;
  logic [7:0]        w_mid;
  logic              w_wr_fire;
  logic [ADDR_W-1:0] w_wcnt_next;

  assign w_ready     = (r_state == S_FILL) || (r_state == S_RUN);
  assign w_accept    = pix_valid_i && w_ready;
  // A start coinciding with frame_done is dropped even though the FSM is already idle
  assign w_start     = start_i && (r_state == S_IDLE) && !r_frame_done;
  assign w_last_pix  = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
  assign w_win_issue = w_accept && (r_row >= c_ROW_TWO) && (r_col >= c_COL_TWO);
  assign w_top       = r_lb0[r_col];
  assign w_mid       = r_lb1[r_col];
  assign w_wr_fire   = res_done_i && r_dly_vld[3];
  assign w_wcnt_next = r_wcnt + ADDR_W'(w_wr_fire);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_FILL;
      S_FILL:  if (w_accept && (r_row == c_ROW_TWO) && (r_col == c_COL_ONE)) w_state_next = S_RUN;
      S_RUN:   if (w_accept && w_last_pix) w_state_next = S_DRAIN;
      S_DRAIN: if (w_wcnt_next == c_WR_TOTAL) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_col        <= '0;
      r_row        <= '0;
      r_pidx       <= '0;
      r_wcnt       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= (r_state == S_DRAIN) && (w_wcnt_next == c_WR_TOTAL);
      if (w_start) begin
        r_col  <= '0;
        r_row  <= '0;
        r_pidx <= '0;
        r_wcnt <= '0;
        r_busy <= 1'b1;
      end else begin
        r_wcnt <= w_wcnt_next;
        if (r_state == S_IDLE) r_busy <= 1'b0;
        if (w_accept) begin
          r_pidx <= r_pidx + 1'b1;
          if (r_col == c_COL_LAST) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
      end
    end
  end

  // Line buffers and column shift registers carry image data only, so they are not reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb0[r_col] <= w_mid;
      r_lb1[r_col] <= pix_i;
      r_t2 <= r_t1;
      r_t1 <= w_top;
      r_m2 <= r_m1;
      r_m1 <= w_mid;
      r_b2 <= r_b1;
      r_b1 <= pix_i;
    end
    if (w_win_issue) begin
      r_s1_win  <= {pix_i, r_b1, r_b2, w_mid, r_m1, r_m2, w_top, r_t1, r_t2};
      r_s1_addr <= r_pidx - c_CTR_OFS;
    end
    if (r_s1_done) r_win_addr <= r_s1_addr;
    r_dly_addr[0] <= r_win_addr;
    for (int i = 1; i < 4; i++) r_dly_addr[i] <= r_dly_addr[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_done  <= 1'b0;
      r_win_done <= 1'b0;
      r_win      <= '0;
      r_dly_vld  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      r_s1_done  <= w_win_issue;
      r_win_done <= r_s1_done;
      if (r_s1_done) r_win <= r_s1_win;
      r_dly_vld  <= {r_dly_vld[2:0], r_win_done};
      r_wr_en    <= w_wr_fire;
      if (w_wr_fire) begin
        r_wr_addr <= r_dly_addr[3];
        r_wr_data <= res_i;
      end
    end
  end

`ifdef SOBEL_FRAME_STATS_EN
  logic [ADDR_W-1:0] r_edge_cnt;

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_edge_cnt <= '0;
    end else if (w_wr_fire && (res_i == 8'hFF)) begin
      r_edge_cnt <= r_edge_cnt + 1'b1;
    end
  end

  assign edge_cnt_o = r_edge_cnt;
`endif

  assign pix_ready_o  = w_ready;
  assign win_o        = r_win;
  assign win_done_o   = r_win_done;
  assign wr_en_o      = r_wr_en;
  assign wr_addr_o    = r_wr_addr;
  assign wr_data_o    = r_wr_data;
  assign busy_o       = r_busy;
  assign frame_done_o = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: scoreboard bench for sobel_window_ctrl on a 5x4 image with a 4-cycle datapath stand-in.
`timescale 1ns/1ps
`default_nettype none

module tb_sobel_window_ctrl;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, start_i, pix_valid_i, res_done_i;
  logic [7:0]    pix_i, res_i;
  logic          pix_ready_o, win_done_o, wr_en_o, busy_o, frame_done_o;
  logic [71:0]   win_o;
  logic [AW-1:0] wr_addr_o;
  logic [7:0]    wr_data_o;
`ifdef SOBEL_FRAME_STATS_EN
  logic [AW-1:0] edge_cnt_o;
`endif

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) u_dut (
`ifdef SOBEL_FRAME_STATS_EN
    .edge_cnt_o   (edge_cnt_o),
`endif
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .pix_valid_i  (pix_valid_i),
    .pix_i        (pix_i),
    .pix_ready_o  (pix_ready_o),
    .win_o        (win_o),
    .win_done_o   (win_done_o),
    .res_i        (res_i),
    .res_done_i   (res_done_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  int fd_cnt = 0, fd_cyc = 0, last_acc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Stimulus frames: 0 uniform 100, 1 vertical step, 2 row ramp
  function automatic int pix_val(input int pat, input int r, input int c);
    case (pat)
      0:       return 100;
      1:       return (c < 2) ? 0 : 200;
      default: return r * 10;
    endcase
  endfunction

  // Hand-computed datapath results at centre (cr, cc)
  function automatic int exp_val(input int pat, input int cc);
    case (pat)
      0:       return 0;
      1:       return (cc == 1 || cc == 2) ? 255 : 0;
      default: return 80;
    endcase
  endfunction

  // Datapath stand-in: signed Gx+Gy clipped to 0..255 so row/column order matters
  function automatic logic [7:0] sob(input logic [71:0] w);
    int d[9];
    int s;
    for (int k = 0; k < 9; k++) d[k] = int'(w[8*k +: 8]);
    s = (d[2] + 2*d[5] + d[8] - d[0] - 2*d[3] - d[6])
      + (d[6] + 2*d[7] + d[8] - d[0] - 2*d[1] - d[2]);
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return 8'(s);
  endfunction

  bit   pv [5];
  logic [7:0] pd [5];
  initial begin
    res_done_i = 1'b0;
    res_i = 8'd0;
    for (int k = 0; k < 5; k++) begin pv[k] = 1'b0; pd[k] = 8'd0; end
    forever begin
      @(negedge clk);
      for (int k = 4; k > 0; k--) begin pv[k] = pv[k-1]; pd[k] = pd[k-1]; end
      pv[0] = (win_done_o === 1'b1);
      pd[0] = sob(win_o);
      res_done_i = pv[4];
      res_i = pd[4];
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (frame_done_o === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
      if (wr_en_o === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: addr %0d data %0d, expected no write (cycle %0d)",
                   wr_addr_o, wr_data_o, cyc);
        end else begin
          e = sb.pop_front();
          check("wr_addr", int'(wr_addr_o), e.addr);
          check("wr_data", int'(wr_data_o), e.data);
          check("wr_latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic send_pixel(input int pat, input int r, input int c, input bit gaps, input bit pulse_start);
    bit rdy;
    int acc;
    if (gaps) begin
      for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) begin
        pix_valid_i = 1'b0;
        tick();
      end
    end
    pix_valid_i = 1'b1;
    pix_i = 8'(pix_val(pat, r, c));
    if (pulse_start) start_i = 1'b1;
    for (int t = 0; ; t++) begin
      rdy = pix_ready_o;
      tick();
      start_i = 1'b0;
      if (rdy) break;
      if (t > 20) begin
        check("pix_ready_timeout", 0, 1);
        break;
      end
    end
    acc = cyc;
    last_acc = acc;
    pix_valid_i = 1'b0;
    if (r >= 2 && c >= 2) sb.push_back('{(r-1)*W + (c-1), exp_val(pat, c-1), acc + 6});
  endtask

  task automatic send_frame(input int pat, input bit gaps, input int n_pix, input int start_at);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_after_start", int'(busy_o), 1);
`ifdef SOBEL_FRAME_STATS_EN
    check("edge_cnt_after_start", int'(edge_cnt_o), 0);
`endif
    for (int i = 0; i < n_pix; i++) send_pixel(pat, i / W, i % W, gaps, i == start_at);
  endtask

  task automatic wait_done(input bit start_on_done);
    int fd0 = fd_cnt;
    for (int t = 0; t < 30 && fd_cnt == fd0; t++) tick();
    check("frame_done_count", fd_cnt - fd0, 1);
    check("frame_done_latency", fd_cyc - last_acc, 6);
    check("all_writes_seen", sb.size(), 0);
    if (start_on_done) begin
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("start_at_done_ignored_ready", int'(pix_ready_o), 0);
    end
    tick();
    tick();
    check("busy_after_done", int'(busy_o), 0);
    check("single_frame_done", fd_cnt - fd0, 1);
  endtask

  task automatic abort_frame(input int pat, input int n_pix);
    int fd0;
    send_frame(pat, 1'b0, n_pix, -1);
    fd0 = fd_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    for (int t = 0; t < 12; t++) tick();
    check("abort_no_frame_done", fd_cnt - fd0, 0);
    check("abort_busy_low", int'(busy_o), 0);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    pix_valid_i = 1'b0;
    pix_i = 8'd0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_pix_ready", int'(pix_ready_o), 0);
    check("rst_win_done", int'(win_done_o), 0);
    check("rst_win_zero", int'(win_o == 72'd0), 1);
    check("rst_wr_en", int'(wr_en_o), 0);
    check("rst_wr_addr", int'(wr_addr_o), 0);
    check("rst_wr_data", int'(wr_data_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_frame_done", int'(frame_done_o), 0);

    send_frame(0, 1'b0, W*H, -1);
    wait_done(1'b0);

    send_frame(1, 1'b0, W*H, -1);
    wait_done(1'b0);
`ifdef SOBEL_FRAME_STATS_EN
    check("edge_cnt_step", int'(edge_cnt_o), 4);
`endif

    send_frame(1, 1'b1, W*H, -1);
    wait_done(1'b1);

    abort_frame(2, 9);
    abort_frame(2, 14);

    send_frame(2, 1'b0, W*H, -1);
    wait_done(1'b0);

    send_frame(0, 1'b0, W*H, 12);
    wait_done(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation reached time limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
